// File: rtl/core_config_pkg.sv
// Core-wide configuration and the types shared by the multiply front end.
package core_config_pkg;
  localparam int XLEN               = 32;
  localparam int MUL_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } mul_seq_state_t;

  function automatic logic op_signed_a(mul_op_t op);
    return op != MUL_OP_MULHU;
  endfunction

  function automatic logic op_signed_b(mul_op_t op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
  endfunction
endpackage

// File: rtl/mul_result_cache.sv
// One-entry store of the last completed full product with a signedness-aware hit check.
module mul_result_cache
  import core_config_pkg::*;
#(
  parameter int XLEN = core_config_pkg::XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              write,
  input  logic [XLEN-1:0]   wr_rs1,
  input  logic [XLEN-1:0]   wr_rs2,
  input  logic              wr_sgn_a,
  input  logic              wr_sgn_b,
  input  logic [2*XLEN-1:0] wr_product,
  input  logic [1:0]        lk_op,
  input  logic [XLEN-1:0]   lk_rs1,
  input  logic [XLEN-1:0]   lk_rs2,
  output logic              hit,
  output logic [2*XLEN-1:0] hit_product
);
  logic              cache_valid;
  logic [XLEN-1:0]   rs1_reg;
  logic [XLEN-1:0]   rs2_reg;
  logic              sgn_a_reg;
  logic              sgn_b_reg;
  logic [2*XLEN-1:0] product_reg;
  mul_op_t           lk_op_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      sgn_a_reg   <= 1'b0;
      sgn_b_reg   <= 1'b0;
      product_reg <= '0;
    end else if (clear) begin
      cache_valid <= 1'b0;
    end else if (write) begin
      cache_valid <= 1'b1;
      rs1_reg     <= wr_rs1;
      rs2_reg     <= wr_rs2;
      sgn_a_reg   <= wr_sgn_a;
      sgn_b_reg   <= wr_sgn_b;
      product_reg <= wr_product;
    end
  end

  assign lk_op_e = mul_op_t'(lk_op);

  // The low word is the same for every signedness pairing, so MUL ignores the sign bits.
  assign hit = cache_valid && (lk_rs1 == rs1_reg) && (lk_rs2 == rs2_reg) &&
               ((lk_op_e == MUL_OP_MUL) ||
                ((op_signed_a(lk_op_e) == sgn_a_reg) && (op_signed_b(lk_op_e) == sgn_b_reg)));
  assign hit_product = product_reg;
endmodule

// File: rtl/mul_sequencer.sv
// Front-end controller for the Booth multiplier: accepts RV32M multiply requests,
// runs the start/done protocol, selects the result word and reuses repeated products.
module mul_sequencer
  import core_config_pkg::*;
#(
  parameter int XLEN           = core_config_pkg::XLEN,
  parameter int TAG_W          = 5,
  parameter int TIMEOUT_CYCLES = MUL_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_err,
  output logic              mul_start,
  output logic [XLEN-1:0]   mul_multiplicand,
  output logic [XLEN-1:0]   mul_multiplier,
  output logic              mul_signed_multiplicand,
  output logic              mul_signed_multiplier,
  input  logic [2*XLEN-1:0] mul_product,
  input  logic              mul_done
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mul_seq_state_t    state_reg;
  mul_op_t           op_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [CNT_W-1:0]  wd_cnt_reg;
  mul_op_t           req_op_e;
  logic              accept;
  logic              wd_expired;
  logic              cache_hit;
  logic              cache_write;
  logic              cache_clear;
  logic [2*XLEN-1:0] cache_product;

  function automatic logic [XLEN-1:0] select_word(mul_op_t op, logic [2*XLEN-1:0] p);
    return (op == MUL_OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign req_op_e    = mul_op_t'(req_op);
  assign req_ready   = (state_reg == IDLE) && !flush;
  assign accept      = req_valid && req_ready;
  assign wd_expired  = wd_cnt_reg >= WD_LAST;
  assign cache_write = (state_reg == WAIT) && mul_done && !flush;
  // A flushed or timed-out operation leaves the cached operands untrustworthy.
  assign cache_clear = (flush && ((state_reg == ISSUE) || (state_reg == WAIT))) ||
                       ((state_reg == WAIT) && !mul_done && wd_expired);

  mul_result_cache #(.XLEN(XLEN)) u_cache (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (cache_clear),
    .write       (cache_write),
    .wr_rs1      (mul_multiplicand),
    .wr_rs2      (mul_multiplier),
    .wr_sgn_a    (mul_signed_multiplicand),
    .wr_sgn_b    (mul_signed_multiplier),
    .wr_product  (mul_product),
    .lk_op       (req_op),
    .lk_rs1      (req_rs1),
    .lk_rs2      (req_rs2),
    .hit         (cache_hit),
    .hit_product (cache_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg               <= IDLE;
      op_reg                  <= MUL_OP_MUL;
      tag_reg                 <= '0;
      wd_cnt_reg              <= '0;
      resp_valid              <= 1'b0;
      resp_data               <= '0;
      resp_tag                <= '0;
      resp_err                <= 1'b0;
      mul_start               <= 1'b0;
      mul_multiplicand        <= '0;
      mul_multiplier          <= '0;
      mul_signed_multiplicand <= 1'b0;
      mul_signed_multiplier   <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state_reg)
        IDLE: if (accept) begin
          op_reg  <= req_op_e;
          tag_reg <= req_tag;
          if (cache_hit) begin
            state_reg  <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= select_word(req_op_e, cache_product);
            resp_tag   <= req_tag;
            resp_err   <= 1'b0;
          end else begin
            state_reg               <= ISSUE;
            mul_start               <= 1'b1;
            mul_multiplicand        <= req_rs1;
            mul_multiplier          <= req_rs2;
            mul_signed_multiplicand <= op_signed_a(req_op_e);
            mul_signed_multiplier   <= op_signed_b(req_op_e);
          end
        end
        ISSUE: begin
          wd_cnt_reg <= '0;
          state_reg  <= flush ? DRAIN : WAIT;
        end
        WAIT: begin
          if (flush) begin
            state_reg <= mul_done ? IDLE : DRAIN;
          end else if (mul_done) begin
            state_reg  <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= select_word(op_reg, mul_product);
            resp_tag   <= tag_reg;
            resp_err   <= 1'b0;
          end else if (wd_expired) begin
            state_reg  <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= '0;
            resp_tag   <= tag_reg;
            resp_err   <= 1'b1;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
          end
        end
        RESP: if (flush || resp_ready) begin
          state_reg  <= IDLE;
          resp_valid <= 1'b0;
        end
        // The multiplier cannot be aborted, so its late product is swallowed here.
        DRAIN: begin
          if (mul_done || wd_expired) begin
            state_reg <= IDLE;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with an 18-cycle multiplier model and a response scoreboard.
`timescale 1ns/1ps
module tb_mul_sequencer;
  localparam int XL      = 32;
  localparam int TW      = 5;
  localparam int MUL_LAT = 18;
  localparam int TMO     = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'd0;
  logic [XL-1:0] req_rs1 = '0;
  logic [XL-1:0] req_rs2 = '0;
  logic [TW-1:0] req_tag = '0;
  logic          flush = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [XL-1:0] resp_data;
  logic [TW-1:0] resp_tag;
  logic          resp_err;
  logic          mul_start;
  logic [XL-1:0] mul_multiplicand;
  logic [XL-1:0] mul_multiplier;
  logic          mul_signed_multiplicand;
  logic          mul_signed_multiplier;
  logic [2*XL-1:0] mul_product = '0;
  logic          mul_done = 1'b0;

  always #5 clk = ~clk;

  mul_sequencer #(.XLEN(XL), .TAG_W(TW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err),
    .mul_start(mul_start), .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_signed_multiplicand(mul_signed_multiplicand), .mul_signed_multiplier(mul_signed_multiplier),
    .mul_product(mul_product), .mul_done(mul_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endfunction

  // Reference arithmetic: extend each operand by its signedness, keep 64 bits.
  function automatic logic [63:0] full_prod(logic [31:0] a, logic [31:0] b, logic sa, logic sb);
    logic [63:0] ea, eb;
    ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  function automatic logic sgn_a_of(logic [1:0] op); return op != 2'd3; endfunction
  function automatic logic sgn_b_of(logic [1:0] op); return op <= 2'd1; endfunction

  function automatic logic [31:0] ref_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    p = full_prod(a, b, sgn_a_of(op), sgn_b_of(op));
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Model of the one-entry result cache.
  bit          mc_valid = 0;
  logic [31:0] mc_a, mc_b;
  logic [1:0]  mc_op;

  function automatic bit model_hit(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    return mc_valid && a == mc_a && b == mc_b &&
           (op == 2'd0 || (sgn_a_of(op) == sgn_a_of(mc_op) && sgn_b_of(op) == sgn_b_of(mc_op)));
  endfunction

  typedef struct { logic [31:0] data; logic [4:0] tag; logic err; } resp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic sa; logic sb; } start_t;
  resp_t  exp_q[$];
  start_t start_q[$];

  // Multiplier model: fixed latency, product from the operands and signedness it was given.
  bit          mul_en = 1;
  int          mul_cnt = 0;
  logic [63:0] mul_pending = '0;
  always @(posedge clk) begin
    #1;
    mul_done = 1'b0;
    if (!rst_n) begin
      mul_cnt = 0;
    end else begin
      if (mul_cnt > 0) begin
        mul_cnt--;
        if (mul_cnt == 0) begin
          mul_done = 1'b1;
          mul_product = mul_pending;
        end
      end
      if (mul_start && mul_en) begin
        mul_cnt = MUL_LAT;
        mul_pending = full_prod(mul_multiplicand, mul_multiplier,
                                mul_signed_multiplicand, mul_signed_multiplier);
      end
    end
  end

  // Per-cycle compare against the expectation queues.
  bit chk_en = 0;
  always @(negedge clk) begin
    #1;
    if (chk_en && rst_n) begin
      if (mul_start) begin
        if (start_q.size() == 0) check("unexpected_mul_start", mul_start, 1'b0);
        else begin
          check("start_multiplicand", mul_multiplicand, start_q[0].a);
          check("start_multiplier", mul_multiplier, start_q[0].b);
          check("start_sgn_a", mul_signed_multiplicand, start_q[0].sa);
          check("start_sgn_b", mul_signed_multiplier, start_q[0].sb);
          start_q.delete(0);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) check("unexpected_resp_valid", resp_valid, 1'b0);
        else begin
          check("resp_data", resp_data, exp_q[0].data);
          check("resp_tag", resp_tag, exp_q[0].tag);
          check("resp_err", resp_err, exp_q[0].err);
          if (resp_ready) exp_q.delete(0);
        end
      end
    end
  end

  task automatic push_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_t s;
    s.a = a; s.b = b; s.sa = sgn_a_of(op); s.sb = sgn_b_of(op);
    start_q.push_back(s);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold, output logic [31:0] data);
    bit    hit;
    int    exp_lat, lat, start_at;
    resp_t r;
    hit   = model_hit(op, a, b);
    r.tag = tag;
    if (!hit && !mul_en) begin
      r.err = 1'b1; r.data = '0; exp_lat = TMO + 2;
    end else begin
      r.err = 1'b0; r.data = ref_result(op, a, b); exp_lat = hit ? 1 : MUL_LAT + 2;
    end
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    #1;
    check("req_ready_idle", req_ready, 1'b1);
    exp_q.push_back(r);
    if (!hit) push_start(op, a, b);
    @(negedge clk);
    req_valid = 1'b0;
    start_at = 0;
    for (lat = 1; lat <= 200; lat++) begin
      #1;
      if (mul_start && start_at == 0) start_at = lat;
      if (resp_valid) break;
      @(negedge clk);
    end
    check("resp_latency", lat, exp_lat);
    check("start_cycle", start_at, hit ? 0 : 1);
    data = resp_data;
    if (resp_valid) begin
      for (int i = 0; i < hold; i++) @(negedge clk);
      @(negedge clk);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      #1;
      check("resp_valid_dropped", resp_valid, 1'b0);
    end
    if (!hit) begin
      mc_valid = mul_en; mc_a = a; mc_b = b; mc_op = op;
    end
  endtask

  task automatic issue_raw(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    push_start(op, a, b);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, wanted completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] d;
    int ready_seen;
    bit drain_ok;

    repeat (3) @(negedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_mul_start", mul_start, 1'b0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_multiplicand", mul_multiplicand, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", req_ready, 1'b1);
    chk_en = 1;

    // MULHU of all-ones operands
    do_req(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h11, 0, d);
    check("mulhu_ones", d, 32'hFFFFFFFE);
    check("mulhu_sgn_a", mul_signed_multiplicand, 1'b0);
    check("mulhu_sgn_b", mul_signed_multiplier, 1'b0);

    // MULH then MUL on the same operands reuses the cached product
    do_req(2'd1, 32'hFFFFFFFE, 32'h3, 5'h02, 0, d);
    check("mulh_m2x3", d, 32'hFFFFFFFF);
    do_req(2'd0, 32'hFFFFFFFE, 32'h3, 5'h03, 0, d);
    check("mul_hit_m2x3", d, 32'hFFFFFFFA);

    // MULHSU after MULH with identical operands must miss
    do_req(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h04, 0, d);
    check("mulh_m1xm1", d, 32'h0);
    do_req(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h05, 0, d);
    check("mulhsu_m1xff", d, 32'hFFFFFFFF);
    check("mulhsu_sgn_a", mul_signed_multiplicand, 1'b1);
    check("mulhsu_sgn_b", mul_signed_multiplier, 1'b0);

    // Flush while idle blocks acceptance
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_rs1 = 32'h7; req_rs2 = 32'h9; req_tag = 5'h06; flush = 1'b1;
    #1;
    check("idle_flush_ready", req_ready, 1'b0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush_no_start", mul_start, 1'b0);

    // Flush five cycles into WAIT: drain, then the cache must be empty
    do_req(2'd0, 32'h1234, 32'h5678, 5'h07, 0, d);
    check("mul_1234x5678", d, 32'h06260060);
    issue_raw(2'd3, 32'h1234, 32'h5678, 5'h08);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    mc_valid = 0;
    ready_seen = 0; drain_ok = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req_ready) ready_seen++;
      if (mul_done) begin drain_ok = 1; break; end
      @(negedge clk);
    end
    check("drain_done_arrived", drain_ok, 1'b1);
    check("drain_ready_low", ready_seen, 0);
    @(negedge clk);
    #1;
    check("drain_exit_ready", req_ready, 1'b1);
    do_req(2'd0, 32'h1234, 32'h5678, 5'h09, 0, d);
    check("mul_after_flush", d, 32'h06260060);

    // Hung multiplier: watchdog error, response held while resp_ready is low
    mul_en = 0;
    do_req(2'd3, 32'hABCD, 32'h1, 5'h0A, 10, d);
    check("timeout_data", d, 32'h0);
    mul_en = 1;

    // Reset during WAIT
    do_req(2'd1, 32'h80000000, 32'h2, 5'h1F, 0, d);
    check("mulh_min_x2", d, 32'hFFFFFFFF);
    issue_raw(2'd3, 32'h80000000, 32'h2, 5'h1E);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_multiplicand", mul_multiplicand, 32'h0);
    check("mid_rst_multiplier", mul_multiplier, 32'h0);
    check("mid_rst_resp_data", resp_data, 32'h0);
    check("mid_rst_resp_tag", resp_tag, 5'h0);
    check("mid_rst_resp_valid", resp_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mc_valid = 0;
    #1;
    check("mid_rst_ready", req_ready, 1'b1);
    do_req(2'd1, 32'h80000000, 32'h2, 5'h1D, 0, d);
    check("mulh_after_reset", d, 32'hFFFFFFFF);

    repeat (3) @(negedge clk);
    check("resp_queue_empty", exp_q.size(), 0);
    check("start_queue_empty", start_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
